// File: rtl/updown_counter_param_if.sv
// -----------------------------------------------------------------------------
// updown_counter_param_if
// Bundles the control, configuration and status signals of the parameterised
// up/down counter. clk and rst are not part of the bundle. They stay plain
// module ports.
//   master : drives controls and limits, observes status (testbench/host side)
//   slave  : the counter itself
// Signals:
//   enable, direction, step, load, load_val, limit_lo, limit_hi, mode, clr_ovf
//       controls and configuration (master -> slave)
//   counter_out, tc, ovf_sticky, cfg_err
//       status (slave -> master)
// -----------------------------------------------------------------------------
interface updown_counter_param_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             direction;
    logic [WIDTH-1:0] step;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit_lo;
    logic [WIDTH-1:0] limit_hi;
    logic             mode;
    logic             clr_ovf;
    logic [WIDTH-1:0] counter_out;
    logic             tc;
    logic             ovf_sticky;
    logic             cfg_err;

    modport master (
        output enable, direction, step, load, load_val,
               limit_lo, limit_hi, mode, clr_ovf,
        input  counter_out, tc, ovf_sticky, cfg_err
    );

    modport slave (
        input  enable, direction, step, load, load_val,
               limit_lo, limit_hi, mode, clr_ovf,
        output counter_out, tc, ovf_sticky, cfg_err
    );
endinterface

// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
// Up/down counter with a configurable width and a step size set at run time.
// It has programmable lower and upper limits, a wrap or saturate mode, a
// parallel load that is clamped to the limits, a registered terminal-count
// pulse and a sticky overflow flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : updown_counter_param_if.slave
//          inputs  enable, direction, step, load, load_val, limit_lo,
//                  limit_hi, mode, clr_ovf
//          outputs counter_out (registered), tc (registered one-cycle pulse),
//                  ovf_sticky (registered), cfg_err (combinational lo > hi)
// Parameters:
//   WIDTH     : counter and limit width, 2..32
//   RESET_VAL : counter_out after reset. It must fit in WIDTH bits.
// -----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 32'd0
) (
    input  logic                        clk,
    input  logic                        rst,
    updown_counter_param_if.slave       bus
);

    logic [WIDTH-1:0] cnt_r;
    logic             tc_r;
    logic             ovf_r;

    logic             cfg_err_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             event_s;
    logic             ovf_nxt_s;

    // Clamp a value into the inclusive range [lo, hi].
    function automatic logic [WIDTH-1:0] clamp_f(
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        logic [WIDTH-1:0] res;
        if (val < lo) begin
            res = lo;
        end else if (val > hi) begin
            res = hi;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Next-state logic: priority is config error, then load, then count, then hold.
    always_comb begin
        cfg_err_s = (bus.limit_lo > bus.limit_hi);
        // One extra bit keeps the carry out (up) and the borrow sign (down).
        // A 16-bit wrap past 0xFFFF therefore never looks like an in-range result.
        sum_s     = {1'b0, cnt_r} + {1'b0, bus.step};
        diff_s    = {1'b0, cnt_r} - {1'b0, bus.step};
        cnt_nxt_s = cnt_r;
        event_s   = 1'b0;

        if (cfg_err_s) begin
            cnt_nxt_s = cnt_r;
        end else if (bus.load) begin
            cnt_nxt_s = clamp_f(bus.load_val, bus.limit_lo, bus.limit_hi);
        end else if (bus.enable) begin
            if (bus.step == {WIDTH{1'b0}}) begin
                // A zero step never moves the counter, even when it is out of range.
                cnt_nxt_s = cnt_r;
            end else if (bus.direction) begin
                if (sum_s <= {1'b0, bus.limit_hi}) begin
                    cnt_nxt_s = sum_s[WIDTH-1:0];
                end else begin
                    event_s   = 1'b1;
                    cnt_nxt_s = bus.mode ? bus.limit_hi : bus.limit_lo;
                end
            end else begin
                if ($signed(diff_s) >= $signed({1'b0, bus.limit_lo})) begin
                    cnt_nxt_s = diff_s[WIDTH-1:0];
                end else begin
                    event_s   = 1'b1;
                    cnt_nxt_s = bus.mode ? bus.limit_lo : bus.limit_hi;
                end
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // A boundary event on the same edge wins over clr_ovf.
        if (event_s) begin
            ovf_nxt_s = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // State registers: counter, terminal-count pulse and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= RESET_VAL[WIDTH-1:0];
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            tc_r  <= event_s;
            ovf_r <= ovf_nxt_s;
        end
    end

    assign bus.counter_out = cnt_r;
    assign bus.tc          = tc_r;
    assign bus.ovf_sticky  = ovf_r;
    assign bus.cfg_err     = cfg_err_s;

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter that succeeds the fixed 8-bit up/down counter. It adds configurable width, runtime step size, programmable lower/upper limits, wrap-or-saturate mode, parallel load, a terminal-count pulse and a sticky overflow flag. It is used as a general event/position counter in lab exercises and feeds display and timer blocks downstream.

Parameters:
WIDTH, 8, counter and limit width in bits (2..32)
RESET_VAL, 0, value of counter_out after reset (must lie in WIDTH bits)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
enable  in  1  count-enable; when low the counter holds (load still honoured)
direction  in  1  1 = count up, 0 = count down
step  in  WIDTH  increment/decrement magnitude per enabled cycle
load  in  1  synchronous parallel load strobe
load_val  in  WIDTH  value to load
limit_lo  in  WIDTH  lower bound (unsigned)
limit_hi  in  WIDTH  upper bound (unsigned)
mode  in  1  0 = wrap to opposite limit, 1 = saturate at limit
clr_ovf  in  1  synchronous clear of ovf_sticky
counter_out  out  WIDTH  current count (registered)
tc  out  1  one-cycle pulse: a boundary event occurred on the previous edge
ovf_sticky  out  1  set on any boundary event; held until clr_ovf or rst
cfg_err  out  1  combinational: limit_lo > limit_hi

Behaviour:
- Reset: counter_out = RESET_VAL, tc = 0, ovf_sticky = 0; takes effect immediately, asynchronous to clk, and mid-count.
- Priority per edge: rst > cfg_err hold > load > enable count > hold.
- cfg_err = 1: counter_out holds, tc = 0, load ignored, ovf_sticky unchanged (clr_ovf still honoured).
- load = 1: counter_out <= load_val clamped to [limit_lo, limit_hi]. Clamping is not a boundary event (tc = 0). load overrides enable.
- Count up (enable = 1, direction = 1): compute sum = counter_out + step in WIDTH+1 bits.
  - sum <= limit_hi: counter_out <= sum.
  - Otherwise a boundary event: mode 0 gives counter_out <= limit_lo; mode 1 gives counter_out <= limit_hi.
- Count down (direction = 0): compute diff = counter_out - step in WIDTH+1 bits, signed.
  - diff >= limit_lo: counter_out <= diff.
  - Otherwise a boundary event: mode 0 gives counter_out <= limit_hi; mode 1 gives counter_out <= limit_lo.
- Out-of-range value (counter_out outside limits, e.g. after a limit change): the next enabled count tests the result against the limits as above. A result beyond the limit is a boundary event.
- step = 0: counter holds, no boundary event, tc = 0.
- Saturated hold: counting further while already at the limit in mode 1 is still a boundary event each cycle. tc pulses every such cycle.
- tc: registered; equals 1 for exactly the cycle after each boundary-event edge, otherwise 0.
- ovf_sticky: set on a boundary-event edge. clr_ovf clears it; a simultaneous boundary event wins (stays 1).
- limit_lo == limit_hi: counter pinned to that value. Any nonzero-step count is a boundary event.
- Latency: counter_out updates on the edge the control is sampled, 1 cycle. No combinational path from inputs to counter_out or tc.

Test Plan:
- Reset/enable: WIDTH=8, RESET_VAL=0; rst pulse, then enable=0 for 3 cycles -> counter_out=0, tc=0. Assert rst mid-count at value 5 -> counter_out=0 immediately, before the next clk edge.
- Wrap up: lo=0, hi=9, step=1, mode=0, up. Count 10 enables from 0 -> sequence 1..9, 0. tc high one cycle after the 9->0 edge. ovf_sticky=1.
- Saturate down with step: lo=2, hi=200, step=5, mode=1, load 10, down -> 5, 2, 2. tc pulses after the 2nd and 3rd edges. clr_ovf with no event -> ovf_sticky=0.
- Load clamping/priority: lo=10, hi=50; load=1, enable=1, load_val=99 -> counter_out=50, tc=0. load_val=3 -> 10.
- Wide/overflow arithmetic: WIDTH=16, lo=0, hi=16'hFFFF, mode=0, step=16'h0010, counter=16'hFFF8, up -> counter_out=0, tc=1. No false in-range result from 16-bit truncation.
- Config error: lo=30, hi=20 -> cfg_err=1, counter holds across enable/load. Restore lo=0 -> cfg_err=0 and counting resumes.
